// File: rtl/fast_command_pkg.sv
// rtl/fast_command_pkg.sv - fast-command word codes, widths and shared helpers
package fast_command_pkg;

  localparam int FC_WORD_BITS = 8;
  localparam int FC_BX_BITS   = 12;

  typedef logic [FC_WORD_BITS-1:0] fc_word_t;
  typedef logic [FC_BX_BITS-1:0]   fc_bx_t;

  localparam fc_word_t IDLE    = 8'hAC;
  localparam fc_word_t L1A     = 8'h2D;
  localparam fc_word_t BCR     = 8'h59;
  localparam fc_word_t BCR_L1A = 8'h5A;

  function automatic fc_bx_t fc_next_bx(input fc_bx_t bx, input int unsigned orbit_len);
    return (bx == FC_BX_BITS'(orbit_len - 1)) ? '0 : bx + FC_BX_BITS'(1);
  endfunction

endpackage

// File: rtl/fc_cmd_fifo.sv
// rtl/fc_cmd_fifo.sv - show-ahead command queue with registered full flag
module fc_cmd_fifo
  import fast_command_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  fc_word_t push_data,
  input  logic     pop,
  output fc_word_t head,
  output logic     empty,
  output logic     full
);

  localparam int AW = $clog2(DEPTH);

  fc_word_t      mem_q [DEPTH];
  fc_word_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d  = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = full_q;

endmodule

// File: rtl/fast_command_encoder.sv
// rtl/fast_command_encoder.sv - BX-framed fast-command serializer; FCE_PRBS_EN adds a PRBS-7 test pattern
module fast_command_encoder
  import fast_command_pkg::*;
#(
  parameter int ORBIT_LENGTH = 3564,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        bcr_en,
  input  logic        l1a,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_code,
  output logic        cmd_ready,
  input  logic        prbs_mode,
  output logic        fast_command,
  output logic        bx_strobe,
  output logic [11:0] bx_count,
  output logic [31:0] orbit_count,
  output logic        l1a_lost
);

  logic [2:0]  phase_q, phase_d;
  fc_word_t    shreg_q, shreg_d;
  fc_bx_t      bx_q, bx_d;
  logic [31:0] orbit_q, orbit_d;
  logic        strobe_q, strobe_d;
  logic        pend_q, pend_d;
  logic        lost_q, lost_d;
  logic        run_q, run_d;

  logic        slot_end;
  fc_bx_t      bx_next;
  fc_word_t    sel_word;
  logic        take_l1a, take_fifo;
  logic        consume, fifo_pop;
  logic        suspend;
  fc_word_t    fifo_head;
  logic        fifo_empty, fifo_full;

  assign slot_end = (phase_q == 3'd7);
  assign bx_next  = fc_next_bx(bx_q, ORBIT_LENGTH);

  fc_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (cmd_valid && cmd_ready),
    .push_data(cmd_code),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // run_q keeps cmd_ready low while reset is held and for its release edge.
  assign cmd_ready = run_q && !fifo_full;

  always_comb begin
    sel_word  = IDLE;
    take_l1a  = 1'b0;
    take_fifo = 1'b0;
    if (enable && !suspend) begin
      if ((bx_next == '0) && bcr_en) begin
        sel_word = pend_q ? BCR_L1A : BCR;
        take_l1a = pend_q;
      end else if (pend_q) begin
        sel_word = L1A;
        take_l1a = 1'b1;
      end else if (!fifo_empty) begin
        sel_word  = fifo_head;
        take_fifo = 1'b1;
      end
    end
  end

  assign consume  = slot_end && take_l1a;
  assign fifo_pop = slot_end && take_fifo;

  always_comb begin
    phase_d  = phase_q + 3'd1;
    strobe_d = slot_end;
    shreg_d  = slot_end ? sel_word : {shreg_q[6:0], 1'b0};
    bx_d     = slot_end ? bx_next : bx_q;
    orbit_d  = (slot_end && (bx_next == '0)) ? orbit_q + 32'd1 : orbit_q;
    run_d    = 1'b1;
    pend_d   = pend_q && !consume;
    lost_d   = lost_q;
    // A pulse landing on the consuming edge replaces the one being sent.
    if (l1a && enable) begin
      if (pend_q && !consume) begin
        lost_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= 3'd0;
      shreg_q  <= IDLE;
      bx_q     <= '0;
      orbit_q  <= '0;
      strobe_q <= 1'b1;
      pend_q   <= 1'b0;
      lost_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      shreg_q  <= shreg_d;
      bx_q     <= bx_d;
      orbit_q  <= orbit_d;
      strobe_q <= strobe_d;
      pend_q   <= pend_d;
      lost_q   <= lost_d;
      run_q    <= run_d;
    end
  end

`ifdef FCE_PRBS_EN
  logic [6:0] lfsr_q, lfsr_d;
  logic       prbs_hold_q, prbs_hold_d;
  logic       prbs_on;

  // Entering PRBS is immediate; leaving waits for the next slot boundary.
  assign prbs_on = prbs_mode || prbs_hold_q;
  assign suspend = prbs_mode;

  always_comb begin
    lfsr_d      = prbs_on ? {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]} : lfsr_q;
    prbs_hold_d = slot_end ? prbs_mode : (prbs_hold_q || prbs_mode);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q      <= 7'h7F;
      prbs_hold_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      prbs_hold_q <= prbs_hold_d;
    end
  end

  assign fast_command = prbs_on ? lfsr_q[6] : shreg_q[7];
`else
  logic unused_prbs_mode;

  assign unused_prbs_mode = prbs_mode;
  assign suspend          = 1'b0;
  assign fast_command     = shreg_q[7];
`endif

  assign bx_strobe   = strobe_q;
  assign bx_count    = bx_q;
  assign orbit_count = orbit_q;
  assign l1a_lost    = lost_q;

endmodule

// File: tb/tb_fast_command_encoder.sv
// tb/tb_fast_command_encoder.sv - directed self-checking bench for fast_command_encoder
`timescale 1ns/1ps
module tb_fast_command_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        bcr_en;
  logic        l1a;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        cmd_ready;
  logic        prbs_mode;
  logic        fast_command;
  logic        bx_strobe;
  logic [11:0] bx_count;
  logic [31:0] orbit_count;
  logic        l1a_lost;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] push_q[$];

  always #2 clk = ~clk;

  fast_command_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bcr_en      (bcr_en),
    .l1a         (l1a),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_ready   (cmd_ready),
    .prbs_mode   (prbs_mode),
    .fast_command(fast_command),
    .bx_strobe   (bx_strobe),
    .bx_count    (bx_count),
    .orbit_count (orbit_count),
    .l1a_lost    (l1a_lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: offer the queued command, then advance to the next falling edge.
  task automatic cyc();
    cmd_valid = (push_q.size() != 0);
    cmd_code  = cmd_valid ? push_q[0] : 8'h00;
    if (cmd_valid && cmd_ready) void'(push_q.pop_front());
    @(negedge clk);
    l1a = 1'b0;
  endtask

  task automatic expect_slot(input string tag, input logic [7:0] l1a_mask,
                             input logic [7:0] exp_w, input int exp_bx);
    logic [7:0]  w;
    logic [7:0]  st;
    logic [11:0] bx;
    bx = bx_count;
    w  = '0;
    st = '0;
    for (int i = 0; i < 8; i++) begin
      w   = {w[6:0], fast_command};
      st  = {st[6:0], bx_strobe};
      l1a = l1a_mask[i];
      cyc();
    end
    check({tag, "_word"}, 32'(w), 32'(exp_w));
    check({tag, "_bx"}, 32'(bx), 32'(exp_bx));
    check({tag, "_strobe"}, 32'(st), 32'h80);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    bcr_en    = 1'b1;
    l1a       = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 8'h00;
    prbs_mode = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_line", 32'(fast_command), 32'd1);
    check("rst_strobe", 32'(bx_strobe), 32'd1);
    check("rst_bx", 32'(bx_count), 32'd0);
    check("rst_orbit", orbit_count, 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_lost", 32'(l1a_lost), 32'd0);
    reset = 1'b0;

    // Orbit 0: IDLE everywhere, no BCR in the very first slot.
    for (int s = 0; s < 3564; s++) expect_slot("orbit0", 8'h00, 8'hAC, s);
    check("orbit_after_28512", orbit_count, 32'd1);
    expect_slot("bcr", 8'h00, 8'h59, 0);
    for (int s = 1; s < 3563; s++) expect_slot("orbit1", 8'h00, 8'hAC, s);
    expect_slot("l1a_bx3563", 8'h08, 8'hAC, 3563);
    check("orbit_two", orbit_count, 32'd2);
    expect_slot("bcr_l1a", 8'h00, 8'h5A, 0);
    expect_slot("after_bcr_l1a", 8'h00, 8'hAC, 1);
    bcr_en = 1'b0;

    // Queued commands with an L1A cutting in.
    push_q = '{8'h11, 8'h22, 8'h33};
    expect_slot("q_push", 8'h00, 8'hAC, 2);
    expect_slot("q_11", 8'h04, 8'h11, 3);
    expect_slot("q_l1a", 8'h00, 8'h2D, 4);
    expect_slot("q_22", 8'h00, 8'h22, 5);
    expect_slot("q_33", 8'h00, 8'h33, 6);
    expect_slot("q_idle", 8'h00, 8'hAC, 7);
    check("q_all_accepted", 32'(push_q.size()), 32'd0);

    // Fill the queue while disabled, then drain.
    enable = 1'b0;
    for (int k = 0; k < 9; k++) push_q.push_back(8'hA0 + 8'(k));
    expect_slot("fill", 8'h00, 8'hAC, 8);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_left", 32'(push_q.size()), 32'd1);
    expect_slot("disabled", 8'h08, 8'hAC, 9);
    check("full_ready_hold", 32'(cmd_ready), 32'd0);
    enable = 1'b1;
    expect_slot("enable_edge", 8'h00, 8'hAC, 10);
    for (int k = 0; k < 9; k++) expect_slot("drain", 8'h00, 8'hA0 + 8'(k), 11 + k);
    expect_slot("drained", 8'h00, 8'hAC, 20);
    check("drain_all_accepted", 32'(push_q.size()), 32'd0);
    check("no_lost_yet", 32'(l1a_lost), 32'd0);

    // Two L1As in one slot: one sent, one lost.
    expect_slot("dbl_l1a", 8'h0A, 8'hAC, 21);
    check("lost_set", 32'(l1a_lost), 32'd1);
    expect_slot("dbl_sent", 8'h00, 8'h2D, 22);
    expect_slot("dbl_after", 8'h00, 8'hAC, 23);
    check("lost_sticky", 32'(l1a_lost), 32'd1);

    // Reset mid-slot with queued commands and a pending L1A.
    push_q = '{8'hB1, 8'hB2, 8'hB3};
    for (int i = 0; i < 4; i++) begin
      l1a = (i == 1);
      cyc();
    end
    reset = 1'b1;
    #1;
    check("mid_rst_line", 32'(fast_command), 32'd1);
    check("mid_rst_strobe", 32'(bx_strobe), 32'd1);
    check("mid_rst_bx", 32'(bx_count), 32'd0);
    check("mid_rst_orbit", orbit_count, 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_lost", 32'(l1a_lost), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) expect_slot("post_rst", 8'h00, 8'hAC, s);
    check("post_rst_orbit", orbit_count, 32'd0);
    check("post_rst_lost", 32'(l1a_lost), 32'd0);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fast_command_encoder.md
# fast_command_encoder

Generates the internal fast-command stream feeding the fast-control fanout's `int_fast_command` input. It runs on the internal 320 MHz fast clock, frames 8-bit command words into 40 MHz bunch-crossing (BX) slots and serializes them MSB-first. Each slot is filled by a fixed priority: automatic BCR at orbit wrap, then L1A, then queued software/firmware commands, then IDLE. It also maintains the BX and orbit counters.

## Interface
- `ORBIT_LENGTH`, default 3564: BX slots per orbit; range 2..4095.
- `FIFO_DEPTH`, default 8: depth of the command queue; must be a power of 2, at least 2.
- `clk` in 1: internal 320 MHz fast clock; all logic is on its rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `enable` in 1: when low, every slot carries IDLE.
- `bcr_en` in 1: enables automatic BCR in BX 0.
- `l1a` in 1: single-cycle trigger pulse.
- `cmd_valid` in 1: command request.
- `cmd_code` in 8: command word, sent verbatim.
- `cmd_ready` out 1: queue can accept a command.
- `prbs_mode` in 1: selects the PRBS-7 test pattern; only active when `FCE_PRBS_EN` is defined.
- `fast_command` out 1: serial stream to the fanout.
- `bx_strobe` out 1: high during bit 7 (MSB) of each slot.
- `bx_count` out 12: BX index of the word currently on the line.
- `orbit_count` out 32: number of completed orbits.
- `l1a_lost` out 1: sticky flag; cleared only by reset.

## Operation
- Package codes: `IDLE`=8'hAC, `L1A`=8'h2D, `BCR`=8'h59, `BCR_L1A`=8'h5A.
- A 3-bit phase counter counts 0..7; phase 0 is the first (MSB) bit of a slot.
- An 8-bit shift register drives `fast_command = shreg[7]` and shifts left each cycle.
- At phase 7 the next word is loaded and `bx_count` advances; it wraps from `ORBIT_LENGTH-1` to 0.
- On wrap to 0, `orbit_count` increments, wrapping modulo 2^32.
- Slot selection at phase 7 for `bx_next`:
  - If `enable`=0: IDLE.
  - Else if `bx_next`==0 and `bcr_en`: BCR_L1A when an L1A is pending (pending cleared), otherwise BCR.
  - Else if an L1A is pending: L1A, pending cleared.
  - Else if the FIFO is non-empty: the FIFO head, popped.
  - Else: IDLE.
- L1A pending:
  - An `l1a` pulse while `enable` sets the pending flag.
  - A pulse while the flag is already set and not being consumed that same cycle sets `l1a_lost` and is discarded.
  - If a pulse coincides with consumption, the new pulse becomes pending.
- Command FIFO:
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready` = !full; it is 0 during reset.
  - Push and pop in the same cycle are allowed when non-empty; occupancy is unchanged.
  - Pushing to an empty FIFO in the phase-7 cycle does not feed that slot.
  - Commands are never dropped.
- `enable` low: no FIFO pops, `l1a` ignored, counters keep running, no auto BCR.
- Reset clears all state: FIFO emptied, pending and `l1a_lost` cleared.
- Reset values:
  - shreg = IDLE, so `fast_command`=1.
  - phase 0, `bx_count` 0, `orbit_count` 0.
  - `bx_strobe`=1 (registered, high during phase 0).
  - `cmd_ready`=0, `l1a_lost`=0.
- The first slot after reset release is IDLE at BX 0, with no BCR even if `bcr_en`.

## Timing
- Slot period is 8 `clk` cycles (25 ns).
- `bx_strobe` and `bx_count` are registered and aligned to phase 0 of the slot they describe.
- A command accepted at or before phase 6 of slot N goes out in slot N+1 if the FIFO was empty and no higher-priority word claims the slot.
- Latency from that accept to the line is 2..9 cycles.
- An `l1a` pulse at phase k of slot N, with nothing pending, goes out in slot N+1; if it arrives at phase 7 it slips to N+2.
- `cmd_ready` reflects the registered full flag; it is low the cycle after the push that fills the FIFO.

## Configuration
- Macro `FCE_PRBS_EN`.
- With it defined: while `prbs_mode`=1, `fast_command` outputs PRBS-7 (x^7+x^6+1, seed 7'h7F at reset, one bit per cycle).
  - Counters keep running.
  - FIFO pops and L1A consumption are suspended.
  - L1A pulses still set `l1a_lost` if one is already pending.
  - Leaving PRBS mode takes effect at the next phase 0 with a freshly selected word.
- Without it: `prbs_mode` is ignored, there is no LFSR logic, and behaviour is identical to `prbs_mode`=0.

## Structure
- Package `fast_command_pkg` holds:
  - the four codes;
  - `FC_WORD_BITS`=8 and `FC_BX_BITS`=12;
  - `fc_word_t` (logic [7:0]).
- Sub-module `fc_cmd_fifo`: synchronous FIFO of `fc_word_t` with `FIFO_DEPTH` entries, async active-high reset, full/empty flags, and show-ahead head.

## Test plan
- Reset release with `enable`=1 and no requests: every slot is 8'hAC MSB-first, `bx_count` runs 0..3563, and `orbit_count` reaches 1 after 28512 cycles.
- `bcr_en`=1 through a full orbit: the slot with `bx_count`=0 carries 8'h59, all others 8'hAC; assert `l1a` in BX 3563 and that slot carries 8'h5A instead.
- Push 8'h11, 8'h22, 8'h33 back-to-back, then a single `l1a` during the slot carrying 8'h11: the next slots are 8'h2D, 8'h22, 8'h33 in that order.
- Push 9 commands at `FIFO_DEPTH`=8 with `enable`=0: `cmd_ready` drops after the 8th; raise `enable` and all 8 drain in order, the 9th is accepted once space frees, and nothing is lost.
- Two `l1a` pulses 2 cycles apart within one slot: one 8'h2D is sent, `l1a_lost`=1 and stays set until reset.
- Assert `reset` at phase 4 with a 3-entry FIFO and a pending L1A: the outputs return to reset values immediately, and after release only 8'hAC appears; with `FCE_PRBS_EN` and `prbs_mode`=1, the first 7 bits after reset are 1111111 followed by the PRBS-7 sequence.
